// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. The line is oversampled on i_Clk, and each bit is sampled at mid-bit.
// Optional: define UART_RX_PARITY_EN for 8E1 frames with a parity check (o_fParErr).
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int LSTCLK   = CLK_FREQ / BAUD,
  parameter int MIDCLK   = LSTCLK / 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic [7:0] o_Data,
  output logic       o_fValid,
  output logic       o_fFrmErr,
  output logic       o_fParErr,
  output logic       o_fBusy
);

  localparam int CW = $clog2(LSTCLK + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} state_t;
`endif

  state_t          state, stateNext;
  logic            rxMeta, sRx;
  logic [CW-1:0]   clkCnt, clkCntNext;
  logic [2:0]      bitCnt, bitCntNext;
  logic [7:0]      shiftReg, shiftNext;
  logic [7:0]      dataReg, dataNext;
  logic            validReg, validNext;
  logic            frmErrReg, frmErrNext;
  logic            midHit, bitEnd, parMis;

  assign midHit = (clkCnt == CW'(MIDCLK));
  assign bitEnd = (clkCnt == CW'(LSTCLK));

`ifdef UART_RX_PARITY_EN
  logic parReg, parNext;
  logic parErrReg, parErrNext;
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign parMis    = parReg ^ (^shiftReg);
  assign o_fParErr = parErrReg;
`else
  assign parMis    = 1'b0;
  assign o_fParErr = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      rxMeta    <= 1'b1;
      sRx       <= 1'b1;
      state     <= IDLE;
      clkCnt    <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      dataReg   <= 8'h00;
      validReg  <= 1'b0;
      frmErrReg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parReg    <= 1'b0;
      parErrReg <= 1'b0;
`endif
    end else begin
      rxMeta    <= i_Rx;
      sRx       <= rxMeta;
      state     <= stateNext;
      clkCnt    <= clkCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      dataReg   <= dataNext;
      validReg  <= validNext;
      frmErrReg <= frmErrNext;
`ifdef UART_RX_PARITY_EN
      parReg    <= parNext;
      parErrReg <= parErrNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (!sRx) stateNext = RX_START;
      RX_START: if (midHit) stateNext = sRx ? IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
      RX_DATA:  if (bitEnd && bitCnt == 3'd7) stateNext = RX_PAR;
      RX_PAR:   if (bitEnd) stateNext = RX_STOP;
`else
      RX_DATA:  if (bitEnd && bitCnt == 3'd7) stateNext = RX_STOP;
`endif
      // A good stop returns to IDLE at mid stop bit so back-to-back frames are caught.
      RX_STOP:  if (bitEnd) stateNext = sRx ? IDLE : RX_WAIT;
      RX_WAIT:  if (sRx) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    clkCntNext = clkCnt;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    dataNext   = dataReg;
    validNext  = 1'b0;
    frmErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parNext    = parReg;
    parErrNext = 1'b0;
`endif
    case (state)
      RX_START: clkCntNext = midHit ? '0 : clkCnt + 1'b1;
      RX_DATA: begin
        if (bitEnd) begin
          clkCntNext = '0;
          shiftNext  = {sRx, shiftReg[7:1]};
          bitCntNext = (bitCnt == 3'd7) ? 3'd0 : bitCnt + 3'd1;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PAR: begin
        if (bitEnd) begin
          clkCntNext = '0;
          parNext    = sRx;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (bitEnd) begin
          clkCntNext = '0;
          validNext  = sRx & ~parMis;
          frmErrNext = ~sRx;
          if (sRx && !parMis) dataNext = shiftReg;
`ifdef UART_RX_PARITY_EN
          parErrNext = parMis;
`endif
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
      default: clkCntNext = '0;
    endcase
  end

  assign o_Data    = dataReg;
  assign o_fValid  = validReg;
  assign o_fFrmErr = frmErrReg;
  assign o_fBusy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BITCLK = 435;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Clocks from the start edge to the visible pulse: sync + half bit + remaining bits.
  localparam int LAT = 2 + 218 + (9 + PAR_EN) * BITCLK;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Rx  = 1'b1;
  logic [7:0] o_Data;
  logic       o_fValid, o_fFrmErr, o_fParErr, o_fBusy;

  uart_rx dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Rx     (i_Rx),
    .o_Data   (o_Data),
    .o_fValid (o_fValid),
    .o_fFrmErr(o_fFrmErr),
    .o_fParErr(o_fParErr),
    .o_fBusy  (o_fBusy)
  );

  always #10 i_Clk = ~i_Clk;

  typedef struct {
    int         t0;
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t        expQ[$];
  ev_t        curEv;
  int         cycle = 0;
  int         nChecks = 0;
  int         nPass = 0;
  int         firstLat = -1;
  int         lat;
  int         nValid = 0, nFrm = 0, nPar = 0;
  logic [7:0] lastGood = 8'h00;

  always @(posedge i_Clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic chkRange(input string name, input int act, input int lo, input int hi);
    nChecks++;
    if (act >= lo && act <= hi) nPass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cycle);
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      lastGood = 8'h00;
      chk("rst_data", int'(o_Data), 0);
      chk("rst_pulses", int'({o_fValid, o_fFrmErr, o_fParErr}), 0);
      chk("rst_busy", int'(o_fBusy), 0);
    end else begin
      if (o_fValid || o_fFrmErr || o_fParErr) begin
        if (expQ.size() == 0) begin
          chk("spurious_pulse", int'({o_fValid, o_fFrmErr, o_fParErr}), 0);
        end else begin
          curEv = expQ.pop_front();
          lat = cycle - curEv.t0;
          if (firstLat < 0) firstLat = lat;
          chkRange("pulse_latency", lat, LAT - 2, LAT + 2);
          chk("pulse_flags", int'({o_fValid, o_fFrmErr, o_fParErr}),
              int'({curEv.v, curEv.fe, curEv.pe}));
          if (curEv.v) lastGood = curEv.d;
          $display("frame t0=%0d byte=%0h valid=%0b frmerr=%0b parerr=%0b data=%0h lat=%0d",
                   curEv.t0, curEv.d, o_fValid, o_fFrmErr, o_fParErr, o_Data, lat);
        end
        nValid += int'(o_fValid);
        nFrm   += int'(o_fFrmErr);
        nPar   += int'(o_fParErr);
      end else if (expQ.size() > 0 && cycle > expQ[0].t0 + LAT + 2) begin
        curEv = expQ.pop_front();
        chk("missing_pulse", int'({o_fValid, o_fFrmErr, o_fParErr}),
            int'({curEv.v, curEv.fe, curEv.pe}));
      end
      chk("data", int'(o_Data), int'(lastGood));
    end
  end

  task automatic drive(input logic v, input int n);
    i_Rx = v;
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input int bitClks, input logic parFlip,
                           input logic stopBit, input int stopClks);
    ev_t e;
    e.t0 = cycle;
    e.d  = d;
    e.fe = !stopBit;
    e.pe = (PAR_EN != 0) && parFlip;
    e.v  = stopBit && !e.pe;
    expQ.push_back(e);
    drive(1'b0, bitClks);
    for (int i = 0; i < 8; i++) drive(d[i], bitClks);
    if (PAR_EN != 0) drive((^d) ^ parFlip, bitClks);
    drive(stopBit, stopClks);
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() > 0 && n < limit) begin
      @(posedge i_Clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", expQ.size(), 0);
  endtask

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation exceeded 95000 cycles, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    i_Rst = 1'b0;
    i_Rx  = 1'b1;
    repeat (5) @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
    drive(1'b1, 20);
    chk("post_reset_busy", int'(o_fBusy), 0);
    chk("post_reset_data", int'(o_Data), 8'h00);

    // Single byte A5
    sendFrame(8'hA5, BITCLK, 1'b0, 1'b1, BITCLK);
    waitDrain(2000);
    drive(1'b1, 50);
    chk("a5_data", int'(o_Data), 8'hA5);
    chk("a5_valid_count", nValid, 1);
    chkRange("a5_latency", firstLat, 4133 + PAR_EN * 435, 4137 + PAR_EN * 435);
    chk("a5_busy_after", int'(o_fBusy), 0);

    // Back-to-back frames with no idle gap
    sendFrame(8'h00, BITCLK, 1'b0, 1'b1, BITCLK);
    sendFrame(8'hFF, BITCLK, 1'b0, 1'b1, BITCLK);
    sendFrame(8'h55, BITCLK, 1'b0, 1'b1, BITCLK);
    waitDrain(2000);
    chk("b2b_data", int'(o_Data), 8'h55);
    chk("b2b_valid_count", nValid, 4);

    // Short low glitch while idle
    drive(1'b0, 100);
    drive(1'b1, 400);
    chk("glitch_busy", int'(o_fBusy), 0);
    chk("glitch_data", int'(o_Data), 8'h55);
    chk("glitch_valid_count", nValid, 4);

    // Bad stop bit, line held low, then recovery
    sendFrame(8'h3C, BITCLK, 1'b0, 1'b0, 2000);
    chk("break_busy_held", int'(o_fBusy), 1);
    drive(1'b1, 100);
    chk("break_busy_released", int'(o_fBusy), 0);
    chk("frmerr_count", nFrm, 1);
    chk("frmerr_data_kept", int'(o_Data), 8'h55);
    sendFrame(8'h81, BITCLK, 1'b0, 1'b1, BITCLK);
    waitDrain(2000);
    chk("after_break_data", int'(o_Data), 8'h81);

    // Reset in the middle of data bit 4 of C3
    rb = 8'hC3;
    drive(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) drive(rb[i], BITCLK);
    drive(rb[4], 200);
    i_Rst = 1'b0;
    i_Rx  = 1'b1;
    drive(1'b1, 5);
    chk("abort_busy", int'(o_fBusy), 0);
    chk("abort_data", int'(o_Data), 8'h00);
    i_Rst = 1'b1;
    drive(1'b1, 50);
    sendFrame(8'h12, BITCLK, 1'b0, 1'b1, BITCLK);
    waitDrain(2000);
    chk("after_abort_data", int'(o_Data), 8'h12);

    // Random bytes, slight baud mismatch, random gaps
    for (int k = 0; k < 3; k++) begin
      int bc;
      bc = int'($urandom_range(431, 439));
      sendFrame(8'($urandom_range(0, 255)), bc, ($urandom_range(0, 3) == 0), 1'b1, bc);
      drive(1'b1, int'($urandom_range(0, 300)));
    end
    waitDrain(5000);

`ifdef UART_RX_PARITY_EN
    // Good then bad parity on 07
    drive(1'b1, 50);
    nPar = 0;
    sendFrame(8'h07, BITCLK, 1'b0, 1'b1, BITCLK);
    waitDrain(2000);
    chk("par_good_data", int'(o_Data), 8'h07);
    sendFrame(8'h07, BITCLK, 1'b1, 1'b1, BITCLK);
    waitDrain(2000);
    chk("par_bad_count", nPar, 1);
    chk("par_bad_data_kept", int'(o_Data), 8'h07);
`endif

    drive(1'b1, 100);
    chk("final_busy", int'(o_fBusy), 0);
    chk("final_queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the team's UART transmitter, with the same baud and clock assumptions.
- Oversamples the asynchronous serial line on i_Clk, validates the start bit at mid-bit, then samples 8 data bits LSB-first and the stop bit.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte-level command/loopback logic.

Parameters:
- CLK_FREQ, 50_000_000: i_Clk frequency in Hz.
- BAUD, 115200: line rate.
- LSTCLK, CLK_FREQ/BAUD (434): last count of a bit period. One bit = LSTCLK+1 clocks, matching the transmitter.
- MIDCLK, LSTCLK/2 (217): count at which the start bit is checked.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  reset, asynchronous, active-low
- i_Rx  input  1  serial line, idle high, asynchronous to i_Clk
- o_Data  output  8  last good received byte
- o_fValid  output  1  one-cycle pulse: o_Data updated with a new byte
- o_fFrmErr  output  1  one-cycle pulse: stop bit sampled low
- o_fParErr  output  1  one-cycle pulse: parity mismatch (only with the optional feature)
- o_fBusy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset:
  - Synchronizer flops are set to 1.
  - ClkCnt=0, BitCnt=0, shift register=0, o_Data=8'h00.
  - All pulse outputs are 0 and the state is IDLE.
  - Reset asserted mid-frame aborts immediately. No pulse is issued and the partial byte is discarded.
- Input sync: i_Rx passes through a 2-FF synchronizer. Only the synchronized s_Rx is used internally.
- IDLE: ClkCnt held at 0. If s_Rx==0, go to RX_START.
- RX_START:
  - ClkCnt increments each clock.
  - At ClkCnt==MIDCLK, if s_Rx==0: ClkCnt<=0 and go to RX_DATA.
  - At ClkCnt==MIDCLK, if s_Rx==1 (glitch/false start): return to IDLE with no pulse.
- RX_DATA:
  - ClkCnt counts 0..LSTCLK and wraps.
  - At ClkCnt==LSTCLK: sample s_Rx into shift register MSB (shift right, LSB first) and increment BitCnt.
  - After the 8th sample (BitCnt==7 at wrap), go to RX_STOP with BitCnt cleared. With the optional feature, go to RX_PAR instead.
- RX_STOP: at ClkCnt==LSTCLK, sample s_Rx.
  - If 1: o_Data<=shift register, pulse o_fValid for 1 cycle, go to IDLE. Returning to IDLE mid stop bit allows back-to-back frames.
  - If 0: pulse o_fFrmErr, leave o_Data unchanged, go to RX_WAIT.
- RX_WAIT (line break / framing recovery): stay until s_Rx==1, then go to IDLE. No new start is detected while the line is held low.
- o_fValid and o_fFrmErr are never both high. Each is registered and asserted in the cycle after the stop-bit sample.
- Latency: o_fValid rises 2+(MIDCLK+1)+9*(LSTCLK+1) = 4135 clocks (±2) after the i_Rx start-bit falling edge.
- Tolerates ±2% baud mismatch: sampling is at mid-bit, with no resync after start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1.
  - State RX_PAR sits between RX_DATA and RX_STOP and samples the parity bit at ClkCnt==LSTCLK.
  - Mismatch against XOR of the 8 data bits: o_fParErr pulses together with the stop-bit result, and o_fValid is suppressed (o_Data unchanged). o_fFrmErr still reports a bad stop bit.
  - Latency grows by LSTCLK+1 clocks.
- Undefined: no RX_PAR state; o_fParErr tied 0.

Test Plan:
- Drive 8N1 byte 8'hA5 at 115200 (435 clocks/bit) -> one o_fValid pulse ~4135 clocks after start edge, o_Data=8'hA5, o_fFrmErr=0, o_fBusy low afterwards.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three o_fValid pulses, o_Data in order 00, FF, 55.
- Low glitch on i_Rx of 100 clocks while IDLE -> return to IDLE at MIDCLK check, no pulses, o_Data unchanged.
- Send 8'h3C with stop bit forced 0, hold line low 2000 clocks, then release and send 8'h81:
  - o_fFrmErr pulse, o_Data keeps the previous value.
  - No spurious start detected during the low hold.
  - o_Data=8'h81 with o_fValid afterwards.
- Assert i_Rst mid data bit 4 of 8'hC3, release, send 8'h12 -> no pulse for the aborted frame, o_Data=8'h12.
- UART_RX_PARITY_EN: send 8'h07 with parity 1 -> o_fValid; resend with parity 0 -> o_fParErr pulse, no o_fValid, o_Data stays 8'h07.
